// File: rtl/rvfi_commit_sequencer.sv
// Reorders tagged commit packets from OoO retire points and emits up to NCH per
// cycle in tag order with running order numbers, halt detection and halt freeze.
module rvfi_commit_sequencer #(
    parameter int NCH   = 2,
    parameter int DEPTH = 16,
    parameter int TAGW  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        in_valid,
    input  logic [NCH*TAGW-1:0]   in_tag,
    input  logic [NCH*134-1:0]    in_pkt,
    input  logic                  flush,
    input  logic [TAGW-1:0]       flush_tag,
    output logic [NCH-1:0]        out_valid,
    output logic [NCH*134-1:0]    out_pkt,
    output logic [NCH*64-1:0]     out_order,
    output logic [NCH-1:0]        out_halt,
    output logic                  halted,
    output logic                  err_overwrite,
    output logic [TAGW:0]         occupancy
);
    localparam int PW = 134;
    localparam int KW = $clog2(NCH + 1);

    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [PW-1:0]      data_q [DEPTH];
    logic [PW-1:0]      data_d [DEPTH];
    logic [TAGW-1:0]    head_q, head_d;
    logic [63:0]        cnt_q, cnt_d;
    logic               halted_q, halted_d;
    logic               err_q, err_d;
    logic [TAGW:0]      occ_q, occ_d;
    logic [NCH-1:0]     ov_q, ov_d;
    logic [NCH-1:0]     oh_q, oh_d;
    logic [NCH*PW-1:0]  op_q, op_d;
    logic [NCH*64-1:0]  oo_q, oo_d;

    logic [KW-1:0]      k;
    logic [DEPTH-1:0]   retire_mask;
    logic [TAGW-1:0]    idx;
    logic [TAGW-1:0]    wtag;
    logic               stop;

    function automatic logic is_halt(input logic [PW-1:0] p);
        return p[101:70] == p[133:102];
    endfunction

    // Scan from head over pre-edge state; a halt packet is the last one taken.
    always_comb begin
        k           = '0;
        stop        = halted_q | flush;
        retire_mask = '0;
        idx         = '0;
        ov_d        = '0;
        oh_d        = '0;
        op_d        = '0;
        oo_d        = '0;
        halted_d    = halted_q;
        for (int j = 0; j < NCH; j++) begin
            idx = head_q + TAGW'(j);
            if (!stop && valid_q[idx]) begin
                k                  = k + KW'(1);
                retire_mask[idx]   = 1'b1;
                ov_d[j]            = 1'b1;
                op_d[j*PW +: PW]   = data_q[idx];
                oo_d[j*64 +: 64]   = cnt_q + 64'(j);
                if (is_halt(data_q[idx])) begin
                    oh_d[j]  = 1'b1;
                    halted_d = 1'b1;
                    stop     = 1'b1;
                end
            end else begin
                stop = 1'b1;
            end
        end
    end

    // Writes land after retirement clears its slots, so a same-edge rewrite of a
    // retiring slot is legal while a second write to a live slot flags an error.
    always_comb begin
        valid_d = valid_q & ~retire_mask;
        data_d  = data_q;
        err_d   = err_q;
        wtag    = '0;
        for (int i = 0; i < NCH; i++) begin
            wtag = in_tag[i*TAGW +: TAGW];
            if (in_valid[i] && !flush) begin
                if (valid_d[wtag]) err_d = 1'b1;
                valid_d[wtag] = 1'b1;
                data_d[wtag]  = in_pkt[i*PW +: PW];
            end
        end
        if (flush) valid_d = '0;
        head_d = flush ? flush_tag : head_q + TAGW'(k);
        cnt_d  = cnt_q + 64'(k);
        occ_d  = '0;
        for (int d = 0; d < DEPTH; d++) begin
            occ_d = occ_d + {{TAGW{1'b0}}, valid_d[d]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            head_q   <= '0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            occ_q    <= '0;
            ov_q     <= '0;
            oh_q     <= '0;
            op_q     <= '0;
            oo_q     <= '0;
        end else begin
            valid_q  <= valid_d;
            head_q   <= head_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
            err_q    <= err_d;
            occ_q    <= occ_d;
            ov_q     <= ov_d;
            oh_q     <= oh_d;
            op_q     <= op_d;
            oo_q     <= oo_d;
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign out_valid     = ov_q;
    assign out_pkt       = op_q;
    assign out_order     = oo_q;
    assign out_halt      = oh_q;
    assign halted        = halted_q;
    assign err_overwrite = err_q;
    assign occupancy     = occ_q;
endmodule

// File: tb/tb_rvfi_commit_sequencer.sv
// Randomized plus directed bench: a slot-array reference model feeds a scoreboard
// that a separate monitor drains whenever the sequencer retires packets.
module tb_rvfi_commit_sequencer;
    localparam int NCH = 2, DEPTH = 16, TAGW = 4, PW = 134;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, flush;
    logic [NCH-1:0]       in_valid;
    logic [NCH*TAGW-1:0]  in_tag;
    logic [NCH*PW-1:0]    in_pkt;
    logic [TAGW-1:0]      flush_tag;
    logic [NCH-1:0]       out_valid, out_halt;
    logic [NCH*PW-1:0]    out_pkt;
    logic [NCH*64-1:0]    out_order;
    logic                 halted, err_overwrite;
    logic [TAGW:0]        occupancy;

    rvfi_commit_sequencer #(.NCH(NCH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_tag(in_tag), .in_pkt(in_pkt),
        .flush(flush), .flush_tag(flush_tag), .out_valid(out_valid), .out_pkt(out_pkt),
        .out_order(out_order), .out_halt(out_halt), .halted(halted),
        .err_overwrite(err_overwrite), .occupancy(occupancy)
    );

    typedef struct {
        logic [PW-1:0]   pkt;
        longint unsigned order;
        bit              halt;
    } exp_t;

    exp_t sb_q[$];
    int   k_q[$];
    int   n_cmp = 0, n_bad = 0;

    // reference model: program-order window as a plain array of slots
    bit              mv[DEPTH];
    logic [PW-1:0]   md[DEPTH];
    int              mhead = 0;
    longint unsigned mcnt = 0;
    bit              mhalt = 0, merr = 0, exp_zero = 0;
    int              exp_occ = 0;

    function automatic bit halt_of(input logic [PW-1:0] p);
        return p[101:70] == p[133:102];
    endfunction

    function automatic logic [PW-1:0] mkpkt(input bit h);
        logic [31:0] r, w;
        r = $urandom;
        w = $urandom;
        if (h) w = r;
        else if (w == r) w = ~r;
        return {r, w, 32'($urandom), 5'($urandom), 32'($urandom), 1'($urandom)};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // Advance the model across the upcoming edge using the inputs now driven.
    task automatic model_step();
        int k, t;
        if (rst) begin
            foreach (mv[i]) mv[i] = 0;
            mhead = 0; mcnt = 0; mhalt = 0; merr = 0; exp_occ = 0; exp_zero = 1;
            sb_q.delete();
            k_q.push_back(0);
            return;
        end
        exp_zero = 0;
        if (flush) begin
            foreach (mv[i]) mv[i] = 0;
            mhead = int'(flush_tag); exp_occ = 0;
            k_q.push_back(0);
            return;
        end
        k = 0;
        while (k < NCH && !mhalt) begin
            t = (mhead + k) % DEPTH;
            if (!mv[t]) break;
            sb_q.push_back(exp_t'{md[t], mcnt + longint'(k), halt_of(md[t])});
            mv[t] = 0;
            k++;
            if (halt_of(md[t])) mhalt = 1;
        end
        mhead = (mhead + k) % DEPTH;
        mcnt  = mcnt + longint'(k);
        k_q.push_back(k);
        for (int i = 0; i < NCH; i++) begin
            if (in_valid[i]) begin
                t = int'(in_tag[i*TAGW +: TAGW]);
                if (mv[t]) merr = 1;
                mv[t] = 1;
                md[t] = in_pkt[i*PW +: PW];
            end
        end
        exp_occ = 0;
        foreach (mv[i]) exp_occ += int'(mv[i]);
    endtask

    task automatic cyc(input bit r, input bit f, input int ft, input logic [1:0] v,
                       input int t0, input int t1, input logic [PW-1:0] p0, input logic [PW-1:0] p1);
        rst = r; flush = f; flush_tag = TAGW'(ft);
        in_valid = v; in_tag = {TAGW'(t1), TAGW'(t0)}; in_pkt = {p1, p0};
        model_step();
        @(posedge clk); #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 2'b00, 0, 0, '0, '0);
    endtask

    task automatic do_rst();
        cyc(1, 0, 0, 2'b00, 0, 0, '0, '0);
    endtask

    task automatic one(input int t);
        cyc(0, 0, 0, 2'b01, t, 0, mkpkt(0), '0);
    endtask

    task automatic two(input int t0, input int t1);
        cyc(0, 0, 0, 2'b11, t0, t1, mkpkt(0), mkpkt(0));
    endtask

    // monitor: drains the scoreboard whenever the DUT presents retirements
    initial begin
        int   kk;
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (k_q.size() == 0) continue;
            kk = k_q.pop_front();
            chk("out_valid", 64'(out_valid), 64'((1 << kk) - 1));
            for (int j = 0; j < NCH; j++) begin
                if (out_valid[j]) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL extra_retire ch%0d: got order %0d, want nothing", j, out_order[j*64 +: 64]);
                    end else begin
                        e = sb_q.pop_front();
                        n_cmp++;
                        if (out_pkt[j*PW +: PW] !== e.pkt || out_order[j*64 +: 64] !== e.order ||
                            out_halt[j] !== e.halt) begin
                            n_bad++;
                            $display("FAIL retire ch%0d: got order=%0d halt=%0b pkt=%h, want order=%0d halt=%0b pkt=%h",
                                     j, out_order[j*64 +: 64], out_halt[j], out_pkt[j*PW +: PW],
                                     e.order, e.halt, e.pkt);
                        end
                    end
                end else begin
                    chk("out_halt_idle", 64'(out_halt[j]), 64'(0));
                end
            end
            chk("occupancy", 64'(occupancy), 64'(exp_occ));
            chk("halted", 64'(halted), 64'(mhalt));
            chk("err_overwrite", 64'(err_overwrite), 64'(merr));
            if (exp_zero) begin
                chk("rst_out_pkt_zero", 64'(out_pkt != '0), 64'(0));
                chk("rst_out_order_zero", 64'(out_order != '0), 64'(0));
            end
        end
    end

    initial begin
        int t;
        logic [1:0] v;
        int tg[2];
        logic [PW-1:0] p[2];
        logic [PW-1:0] pa, pb;

        do_rst();
        // single tags on successive cycles
        one(0); one(1); idle(3);
        // reversed arrival: 3,2 then 1,0
        do_rst(); two(3, 2); idle(2); two(1, 0); idle(3);
        // gap at tag 1
        do_rst(); two(0, 2); idle(2); one(1); idle(3);
        // 40 in-order commits wrapping the window
        do_rst();
        for (int i = 0; i < 40; i++) one(i % DEPTH);
        idle(2);
        // halt at tag 0 freezes tag 1
        do_rst();
        pa = mkpkt(0); pa[133:102] = 32'h60; pa[101:70] = 32'h60;
        cyc(0, 0, 0, 2'b11, 0, 1, pa, mkpkt(0)); idle(4);
        // overwrite of tag 5, then drain to observe the surviving data
        do_rst();
        pa = mkpkt(0); pb = mkpkt(0);
        cyc(0, 0, 0, 2'b01, 5, 0, pa, '0);
        cyc(0, 0, 0, 2'b01, 5, 0, pb, '0);
        two(0, 1); two(2, 3); one(4); idle(4);
        // flush to tag 9, order continues
        do_rst(); two(0, 1); one(3); idle(1);
        cyc(0, 1, 9, 2'b11, 4, 5, mkpkt(0), mkpkt(0));
        idle(1); two(9, 10); idle(3);
        // mid-stream reset
        two(11, 12); do_rst(); idle(2);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if (mhalt && $urandom_range(3) == 0) begin
                do_rst();
            end else if ($urandom_range(59) == 0) begin
                do_rst();
            end else if ($urandom_range(49) == 0) begin
                cyc(0, 1, int'($urandom_range(DEPTH - 1)), 2'($urandom), int'($urandom_range(15)),
                    int'($urandom_range(15)), mkpkt(0), mkpkt(0));
            end else begin
                v = 2'b00;
                for (int i = 0; i < NCH; i++) begin
                    t = (mhead + int'($urandom_range(5))) % DEPTH;
                    tg[i] = t;
                    p[i]  = mkpkt($urandom_range(39) == 0);
                    if ($urandom_range(9) < 7 && (!mv[t] || $urandom_range(19) == 0)) v[i] = 1'b1;
                end
                cyc(0, 0, 0, v, tg[0], tg[1], p[0], p[1]);
            end
        end
        idle(3);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rvfi_commit_sequencer.md
Name: rvfi_commit_sequencer

Overview:
- Parametrised commit-stream sequencer for the CPU's formal-monitor path.
- Accepts up to NCH tagged commit packets per cycle, possibly out of program order, from the pipeline's retire points.
- Buffers them in a DEPTH-slot reorder window and emits up to NCH packets per cycle strictly in tag order.
- Each emitted packet carries a running 64-bit order number, per-packet halt detection and a sticky halt freeze, so multi-issue/OoO cores can drive RVFI.

Parameters:
NCH, 2, input and output commit channels per cycle (1..4)
DEPTH, 16, reorder slots, power of 2, must be >= 2*NCH
TAGW, $clog2(DEPTH), tag width (derived, do not override)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  NCH  per-channel commit strobe
in_tag  in  NCH*TAGW  program-order slot tag per channel
in_pkt  in  NCH*134  packet per channel: [133:102] pc_rdata, [101:70] pc_wdata, [69:38] inst, [37:33] rd_addr, [32:1] rd_wdata, [0] trap
flush  in  1  discard all buffered entries
flush_tag  in  TAGW  new head tag after flush
out_valid  out  NCH  per-channel retire strobe, channel 0 oldest
out_pkt  out  NCH*134  retired packet, same layout
out_order  out  NCH*64  order number of each retired packet
out_halt  out  NCH  retired packet has pc_wdata == pc_rdata
halted  out  1  sticky: a halt packet has retired
err_overwrite  out  1  sticky: write hit an already-valid slot
occupancy  out  TAGW+1  count of valid slots

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: head=0, all slot valid bits=0, order counter=0. out_valid, out_halt, halted, err_overwrite, occupancy=0. out_pkt and out_order=0.
- Reset has priority over every other input, including a mid-burst reset. The cycle after rst, no stale entry is retired.

Write:
- At each edge with in_valid[i]=1, slot[in_tag[i]] becomes valid and stores in_pkt[i].
- Two channels with the same tag in one cycle: the higher channel index wins and err_overwrite is set.
- A write to a slot that is valid and not retiring this edge: data is overwritten and err_overwrite is set.

Retire:
- Each cycle, compute k = number of consecutive valid slots starting at head, capped at NCH. This uses pre-edge state.
- At the edge: out_valid[j]=1 for j<k, and out_pkt[j] = slot[head+j].
- Other effects at the same edge: out_order[j] = counter+j, counter += k, those slots are cleared, and head += k mod DEPTH (wrap-around).
- Outputs are registered. A packet written at edge E appears on out_* after edge E+1, at the earliest.
- The same edge may retire a slot and write the same tag. The write wins: the slot is valid with the new data, and err_overwrite is not set.
- Halt: out_halt[j] = out_valid[j] && pc_wdata==pc_rdata.
  - When any retiring packet has a halt, k is truncated to include that packet, and halted is set.
  - While halted=1, k=0. Writes are still accepted. Only rst clears halted.
- Trap: passes through in the packet. It does not affect sequencing.

Flush and occupancy:
- flush=1: all valid bits cleared, head=flush_tag, and that cycle's retirement and writes are suppressed. out_valid=0 the next cycle. The counter is kept.
- occupancy is the registered count after the edge: +writes to empty slots, −k, 0 on flush.
- Tags are not checked against the window. The producer must keep in-flight tags within DEPTH of head.

Test Plan:
- NCH=2: tag 0 alone, next cycle tag 1 alone → out_valid=01 on two successive cycles, out_order 0 then 1, 2-edge latency each.
- Tags 3,2 in cycle A, then 1,0 in cycle B → nothing until tag 0 lands. Then tags 0,1 retire with order 0,1, and next cycle tags 2,3 with order 2,3.
- Tags 0,2 valid, tag 1 missing → only tag 0 retires. When tag 1 arrives, tags 1,2 retire together with order 1,2.
- Stream of 40 in-order commits, DEPTH=16 → head wraps 15→0, order reaches 39 with no gaps, occupancy never exceeds 2.
- Tags 0,1 written, with tag 0 having pc_rdata=pc_wdata=0x60 → only tag 0 retires, out_halt=01, halted=1. Tag 1 never retires.
- Tag 5 written twice with no retire → err_overwrite=1 with second data kept.
- flush with flush_tag=9 → occupancy=0, and a later tag 9 retires with order continuing.
- rst mid-stream → all outputs 0 next cycle.
